// File: rtl/microsequencer_pkg.sv
// Shared MIR field layout, sequencer defaults and
// the successor-selection code used by the sequencer.
package microsequencer_pkg;

  localparam int ADDR_W_DEF     = 9;
  localparam int MBR_W_DEF      = 8;
  localparam int STACK_DEF      = 4;
  localparam int RESET_ADDR_DEF = 0;

  // MIR layout: classic MIC-1 fields plus CALL/RET extension
  localparam int MIR_W          = 47;
  localparam int NEXT_ADDR_LSB  = 27;
  localparam int NEXT_ADDR_W    = 9;
  localparam int JMPC_BIT       = 26;
  localparam int JAMN_BIT       = 25;
  localparam int JAMZ_BIT       = 24;
  localparam int RET_BIT        = 36;
  localparam int CALL_BIT       = 37;
  localparam int CALL_ADDR_LSB  = 38;
  localparam int CALL_ADDR_W    = 9;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_CALL,
    OP_OVF,
    OP_RET,
    OP_UNF,
    OP_REPL
  } op_e;

endpackage

// File: rtl/usq_stack.sv
// Microcode return-address LIFO.
// Storage is not reset; only the count is.
module usq_stack #(
  parameter int W = 9,
  parameter int D = 4,
  localparam int DW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [D];
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cnt + 1'b1;
    end else if (pop) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (push && int'(cnt) == i) begin
        mem[i] <= din;
      end else if (replace && int'(cnt) == i + 1) begin
        mem[i] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < D; i++) begin
      if (int'(cnt) == i + 1) top = mem[i];
    end
  end

  assign depth = cnt;
  assign full  = (int'(cnt) == D);
  assign empty = (cnt == '0);

endmodule

// File: rtl/microsequencer.sv
// MIC-1 next-MPC logic with N/Z latch, JAM/JMPC
// steering, call/return stack and sticky errors.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MBR_W       = MBR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEF,
  parameter int RESET_ADDR  = RESET_ADDR_DEF,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              N,
  input  logic              Z,
  input  logic [MBR_W-1:0]  MBR,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              jmpc,
  input  logic              jamn,
  input  logic              jamz,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] MPC,
  output logic [DW-1:0]     depth,
  output logic              ovf,
  output logic              unf
);

  logic              n_s, z_s, hb;
  logic [ADDR_W-1:0] seq, top, mpc_nxt;
  logic              full, empty;
  logic              push, pop, repl;
  logic              ovf_set, unf_set;
  op_e               op;

  always_comb begin
    hb  = next_addr[ADDR_W-1] | (jamn & n_s) | (jamz & z_s);
    seq = {hb, next_addr[ADDR_W-2:0]};
    if (jmpc) seq = seq | ADDR_W'(MBR);
  end

  // RET with a non-empty stack outranks CALL
  always_comb begin
    if (ret && !empty) op = call ? OP_REPL : OP_RET;
    else if (call)     op = full ? OP_OVF : OP_CALL;
    else if (ret)      op = OP_UNF;
    else               op = OP_SEQ;
  end

  always_comb begin
    mpc_nxt = seq;
    push    = 1'b0;
    pop     = 1'b0;
    repl    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_SEQ:  mpc_nxt = seq;
      OP_CALL: begin
        mpc_nxt = call_addr;
        push    = !stall;
      end
      OP_OVF:  ovf_set = 1'b1;
      OP_RET:  begin
        mpc_nxt = top;
        pop     = !stall;
      end
      OP_UNF:  begin
        mpc_nxt = ADDR_W'(RESET_ADDR);
        unf_set = 1'b1;
      end
      OP_REPL: begin
        mpc_nxt = call_addr;
        repl    = !stall;
      end
      default: mpc_nxt = seq;
    endcase
  end

  usq_stack #(
    .W(ADDR_W),
    .D(STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .replace (repl),
    .din     (seq),
    .top     (top),
    .depth   (depth),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MPC <= ADDR_W'(RESET_ADDR);
      n_s <= 1'b0;
      z_s <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!stall) begin
      MPC <= mpc_nxt;
      n_s <= N;
      z_s <= Z;
      ovf <= (ovf & ~clr_err) | ovf_set;
      unf <= (unf & ~clr_err) | unf_set;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench: driver pushes model results,
// monitor pops and compares after each clock edge.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, N, Z, jmpc, jamn, jamz;
  logic       call, ret, clr_err;
  logic [7:0] MBR;
  logic [8:0] next_addr, call_addr, MPC;
  logic [2:0] depth;
  logic       ovf, unf;

  microsequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .N(N), .Z(Z),
    .MBR(MBR), .next_addr(next_addr), .jmpc(jmpc),
    .jamn(jamn), .jamz(jamz), .call(call), .ret(ret),
    .call_addr(call_addr), .clr_err(clr_err),
    .MPC(MPC), .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mpc;
    int dep;
    int ov;
    int un;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_mpc, m_ns, m_zs, m_ovf, m_unf;
  int   m_stk[$];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mpc", int'(MPC), e.mpc);
        chk("depth", int'(depth), e.dep);
        chk("ovf", int'(ovf), e.ov);
        chk("unf", int'(unf), e.un);
      end
    end
  end

  task automatic cyc(input int st, input int n, input int z,
                     input int mb, input int na, input int jc,
                     input int jn, input int jz, input int cl,
                     input int rt, input int ca, input int ce);
    int s, o, u;
    exp_t e;
    @(negedge clk);
    stall = st[0]; N = n[0]; Z = z[0]; MBR = 8'(mb);
    next_addr = 9'(na); jmpc = jc[0]; jamn = jn[0];
    jamz = jz[0]; call = cl[0]; ret = rt[0];
    call_addr = 9'(ca); clr_err = ce[0];
    if (st == 0) begin
      o = 0;
      u = 0;
      s = na % 256;
      if ((na / 256) % 2 == 1 || (jn != 0 && m_ns != 0) ||
          (jz != 0 && m_zs != 0)) s = s + 256;
      if (jc != 0) s = s | mb;
      if (rt != 0 && m_stk.size() > 0) begin
        if (cl != 0) begin
          m_stk[m_stk.size() - 1] = s;
          m_mpc = ca;
        end else begin
          m_mpc = m_stk.pop_back();
        end
      end else if (cl != 0) begin
        if (m_stk.size() < 4) begin
          m_stk.push_back(s);
          m_mpc = ca;
        end else begin
          m_mpc = s;
          o = 1;
        end
      end else if (rt != 0) begin
        m_mpc = 0;
        u = 1;
      end else begin
        m_mpc = s;
      end
      m_ovf = ((m_ovf != 0 && ce == 0) || o != 0) ? 1 : 0;
      m_unf = ((m_unf != 0 && ce == 0) || u != 0) ? 1 : 0;
      m_ns = n;
      m_zs = z;
    end
    e.mpc = m_mpc;
    e.dep = m_stk.size();
    e.ov  = m_ovf;
    e.un  = m_unf;
    q.push_back(e);
  endtask

  task automatic seqc(input int na);
    cyc(0, 0, 0, 0, na, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_mpc = 0; m_ns = 0; m_zs = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; N = 1'b0; Z = 1'b0;
    MBR = '0; next_addr = '0; jmpc = 1'b0; jamn = 1'b0;
    jamz = 1'b0; call = 1'b0; ret = 1'b0;
    call_addr = '0; clr_err = 1'b0;
    model_reset();
    #1;
    chk("por_mpc", int'(MPC), 0);
    chk("por_depth", int'(depth), 0);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-run
    cyc(0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 'h050, 0);
    cyc(0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 'h060, 0);
    seqc('h1A5);
    settle();
    chk("pre_rst_mpc", int'(MPC), 'h1A5);
    chk("pre_rst_depth", int'(depth), 2);
    #1 rst = 1'b0;
    #1;
    chk("rst_mpc", int'(MPC), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // JAMN steering, 2-edge N latency
    cyc(0, 1, 0, 0, 'h000, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 'h000, 0, 1, 0, 0, 0, 0, 0);
    settle();
    chk("jamn_n1", int'(MPC), 'h100);
    cyc(0, 0, 0, 0, 'h000, 0, 1, 0, 0, 0, 0, 0);
    settle();
    chk("jamn_n0", int'(MPC), 'h000);

    // JMPC with JAMZ
    cyc(0, 0, 1, 0, 'h000, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 'h55, 'h0F0, 1, 0, 1, 0, 0, 0, 0);
    settle();
    chk("jmpc_jamz1", int'(MPC), 'h1F5);
    cyc(0, 0, 1, 'h55, 'h0F0, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("jmpc_jamz0", int'(MPC), 'h0F5);

    // nested calls, overflow, returns, underflow
    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 0, 0, i, 0, 0, 0, 1, 0, 16 * i, 0);
    settle();
    chk("nest_depth", int'(depth), 4);
    chk("nest_mpc", int'(MPC), 'h040);
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 'h050, 0);
    settle();
    chk("ovf_mpc", int'(MPC), 5);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_depth", int'(depth), 4);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 0, 0, 'h0AA, 0, 0, 0, 0, 1, 0, 0);
      settle();
      chk("ret_mpc", int'(MPC), i);
    end
    chk("ret_depth", int'(depth), 0);
    cyc(0, 0, 0, 0, 'h0AA, 0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("unf_mpc", int'(MPC), 0);
    chk("unf_flag", int'(unf), 1);
    cyc(0, 0, 0, 0, 'h011, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_unf", int'(unf), 0);

    // stall freezes everything including N_s
    cyc(0, 0, 0, 0, 'h033, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, (i + 1) % 2, 0, 0, 'h077, 0, 1, 0, i % 2,
          0, 'h1FF, 1);
    settle();
    chk("stall_mpc", int'(MPC), 'h033);
    chk("stall_depth", int'(depth), 0);
    cyc(0, 0, 0, 0, 'h000, 0, 1, 0, 0, 0, 0, 0);
    settle();
    chk("stall_ns", int'(MPC), 'h000);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 7) == 0) ? 1 : 0,
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 255), $urandom_range(0, 511),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          $urandom_range(0, 511),
          ($urandom_range(0, 9) == 0) ? 1 : 0);
    settle();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
